// File: rtl/conv2_fmap_mem_read.sv
// ---------------------------------------------------------------------------
// conv2_fmap_mem_read
//
// Read-address generator for the Convolution 2 input feature-map memory.
// That memory holds the pooled Convolution 1 output: CH square maps of
// IN_W x IN_W words, stored back to back.
//
// For every input channel and every OUT_W x OUT_W output pixel, the block
// walks the matching K x K window in row-major tap order (taps 0..K*K-1).
// That order is the same as the weight addresser's, so the MAC stage pairs
// feature-map word N with weight word N on every cycle.
//
// One tap is issued per enabled cycle, with no bubbles between windows,
// pixels or channels. Read data returns one cycle after addr; the consumer
// aligns it.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-low; clears every counter, base and done
//   enable      advance one tap per cycle while high and done is low
//   addr        feature-map read address of the current tap (combinational
//               from registered bases)
//   addr_valid  enable && !done: addr is a live tap this cycle
//   tap_first   live tap is tap 0 of its window
//   tap_last    live tap is tap K*K-1 of its window
//   pixel_last  tap_last on the final output pixel of the channel
//   channel     current input channel, 0..CH-1
//   done        registered; set once every tap has been issued and held
//               until reset
// ---------------------------------------------------------------------------
module conv2_fmap_mem_read #(
    parameter int IN_W   = 12,
    parameter int K      = 5,
    parameter int OUT_W  = 8,
    parameter int CH     = 3,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic [ADDR_W-1:0] addr,
    output logic              addr_valid,
    output logic              tap_first,
    output logic              tap_last,
    output logic              pixel_last,
    output logic [1:0]        channel,
    output logic              done
);

    // Counter widths. The guard keeps a 1-wide counter legal if K or OUT_W
    // is ever set to 1.
    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam int OW = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    localparam logic [KW-1:0] K_LAST  = KW'(K - 1);
    localparam logic [OW-1:0] O_LAST  = OW'(OUT_W - 1);
    localparam logic [1:0]    CH_LAST = 2'(CH - 1);

    // Base increments. Every base moves by add only, so no multiplier is
    // needed to form kr*IN_W, orow*IN_W or ch*IN_W*IN_W.
    //   TAP_ROW_STEP: from the last column of a kernel row to the first
    //                 column of the next row, i.e. IN_W-(K-1).
    //   PIX_ROW_STEP: from the last output column to the first column of
    //                 the next output row, i.e. IN_W-(OUT_W-1).
    //   CH_STEP:      size of one channel plane.
    localparam logic [ADDR_W-1:0] TAP_ROW_STEP = ADDR_W'(IN_W - (K - 1));
    localparam logic [ADDR_W-1:0] PIX_ROW_STEP = ADDR_W'(IN_W - (OUT_W - 1));
    localparam logic [ADDR_W-1:0] CH_STEP      = ADDR_W'(IN_W * IN_W);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [KW-1:0]     kc_reg,       kc_next;
    logic [KW-1:0]     kr_reg,       kr_next;
    logic [OW-1:0]     oc_reg,       oc_next;
    logic [OW-1:0]     orow_reg,     orow_next;
    logic [1:0]        ch_reg,       ch_next;
    logic [ADDR_W-1:0] tap_off_reg,  tap_off_next;
    logic [ADDR_W-1:0] pix_base_reg, pix_base_next;
    logic [ADDR_W-1:0] ch_base_reg,  ch_base_next;
    logic              done_reg,     done_next;

    // -----------------------------------------------------------------------
    // Wrap detection
    // -----------------------------------------------------------------------
    logic advance;
    logic col_end;      // last column of the kernel row
    logic win_end;      // last tap of the window
    logic orow_end;     // last output column of the output row
    logic pix_end;      // last tap of the last pixel of the channel
    logic run_end;      // last tap of the last channel

    always_comb begin
        advance  = enable && !done_reg;
        col_end  = (kc_reg == K_LAST);
        win_end  = col_end && (kr_reg == K_LAST);
        orow_end = (oc_reg == O_LAST);
        pix_end  = win_end && orow_end && (orow_reg == O_LAST);
        run_end  = pix_end && (ch_reg == CH_LAST);
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    //
    // A window wrap, a pixel wrap and a channel wrap can all land on the
    // same edge. They are resolved in one nested decision, so tap_off,
    // pix_base and ch_base always move together on that edge.
    //
    // On the very last tap only done is set. Every counter keeps its final
    // value, so addr keeps showing the last address after completion.
    // -----------------------------------------------------------------------
    always_comb begin
        kc_next       = kc_reg;
        kr_next       = kr_reg;
        oc_next       = oc_reg;
        orow_next     = orow_reg;
        ch_next       = ch_reg;
        tap_off_next  = tap_off_reg;
        pix_base_next = pix_base_reg;
        ch_base_next  = ch_base_reg;
        done_next     = done_reg;

        if (advance) begin
            if (run_end) begin
                done_next = 1'b1;
            end else if (!col_end) begin
                kc_next      = kc_reg + KW'(1);
                tap_off_next = tap_off_reg + ADDR_W'(1);
            end else if (!win_end) begin
                kc_next      = '0;
                kr_next      = kr_reg + KW'(1);
                tap_off_next = tap_off_reg + TAP_ROW_STEP;
            end else begin
                // Window finished: restart the tap walk and step the pixel.
                kc_next      = '0;
                kr_next      = '0;
                tap_off_next = '0;
                if (!orow_end) begin
                    oc_next       = oc_reg + OW'(1);
                    pix_base_next = pix_base_reg + ADDR_W'(1);
                end else if (orow_reg != O_LAST) begin
                    oc_next       = '0;
                    orow_next     = orow_reg + OW'(1);
                    pix_base_next = pix_base_reg + PIX_ROW_STEP;
                end else begin
                    // Channel finished (this is not the last channel,
                    // because run_end was false): step to the next plane.
                    oc_next       = '0;
                    orow_next     = '0;
                    pix_base_next = '0;
                    ch_next       = ch_reg + 2'd1;
                    ch_base_next  = ch_base_reg + CH_STEP;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kc_reg       <= '0;
            kr_reg       <= '0;
            oc_reg       <= '0;
            orow_reg     <= '0;
            ch_reg       <= '0;
            tap_off_reg  <= '0;
            pix_base_reg <= '0;
            ch_base_reg  <= '0;
            done_reg     <= 1'b0;
        end else begin
            kc_reg       <= kc_next;
            kr_reg       <= kr_next;
            oc_reg       <= oc_next;
            orow_reg     <= orow_next;
            ch_reg       <= ch_next;
            tap_off_reg  <= tap_off_next;
            pix_base_reg <= pix_base_next;
            ch_base_reg  <= ch_base_next;
            done_reg     <= done_next;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    //
    // The flags are qualified only by enable and done. While reset is held
    // with enable high, the block already shows tap 0 of channel 0 as live.
    // -----------------------------------------------------------------------
    always_comb begin
        addr       = ch_base_reg + pix_base_reg + tap_off_reg;
        addr_valid = advance;
        tap_first  = advance && (kc_reg == '0) && (kr_reg == '0);
        tap_last   = advance && win_end;
        pixel_last = advance && pix_end;
        channel    = ch_reg;
        done       = done_reg;
    end

endmodule

// File: tb/tb_conv2_fmap_mem_read.sv
`timescale 1ns/1ps
module tb_conv2_fmap_mem_read;

    localparam int TOTAL     = 4800;          // 3 channels * 64 pixels * 25 taps
    localparam int STALL_IDX = 7;             // tap index presenting addr 14
    localparam int RST_IDX   = 1600 + 20*25 + 7; // channel 1, pixel 20, tap 7

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [8:0] addr;
    logic       addr_valid;
    logic       tap_first;
    logic       tap_last;
    logic       pixel_last;
    logic [1:0] channel;
    logic       done;

    conv2_fmap_mem_read dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .addr       (addr),
        .addr_valid (addr_valid),
        .tap_first  (tap_first),
        .tap_last   (tap_last),
        .pixel_last (pixel_last),
        .channel    (channel),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] addr;
        logic [1:0] ch;
        logic       first;
        logic       last;
        logic       plast;
    } exp_t;

    exp_t q[$];
    int vectors     = 0;
    int miscompares = 0;
    int n_valid     = 0;
    int idx         = 0;   // number of taps the model has handed to the DUT

    // Reference: tap i of the whole run, computed directly from the
    // channel / pixel / tap decomposition of i.
    function automatic exp_t exp_of(input int i);
        exp_t e;
        int t, p, c;
        t = i % 25;
        p = (i / 25) % 64;
        c = i / 1600;
        e.addr  = 9'(c*144 + ((p / 8) + (t / 5))*12 + (p % 8) + (t % 5));
        e.ch    = 2'(c);
        e.first = (t == 0);
        e.last  = (t == 24);
        e.plast = (t == 24) && (p == 63);
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every live tap presented by the DUT is matched against the
    // next entry of the scoreboard queue.
    always @(negedge clk) begin
        if (reset && addr_valid) begin
            chk("expect_pending", (q.size() > 0) ? 1 : 0, 1);
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                n_valid++;
                vectors++;
                if (addr !== e.addr || channel !== e.ch || tap_first !== e.first ||
                    tap_last !== e.last || pixel_last !== e.plast) begin
                    miscompares++;
                    $display("FAIL tap_out: got addr=%0d ch=%0d first=%0b last=%0b plast=%0b expected addr=%0d ch=%0d first=%0b last=%0b plast=%0b",
                             addr, channel, tap_first, tap_last, pixel_last,
                             e.addr, e.ch, e.first, e.last, e.plast);
                end
            end
            $display("tap addr=%0d ch=%0d first=%0b last=%0b plast=%0b",
                     addr, channel, tap_first, tap_last, pixel_last);
        end
    end

    // One clock cycle of stimulus. An enabled cycle before completion
    // queues the expected tap. An idle or finished cycle is checked here
    // for a held address and low flags.
    task automatic step(input logic en);
        int   i0;
        logic done_exp;
        logic live;
        int   hold_addr;
        @(posedge clk);
        #1;
        enable   = en;
        i0       = idx;
        done_exp = (idx == TOTAL);
        live     = en && !done_exp;
        if (live) begin
            q.push_back(exp_of(idx));
            idx++;
        end
        @(negedge clk);
        chk("done", int'(done), int'(done_exp));
        if (!live) begin
            hold_addr = done_exp ? int'(exp_of(TOTAL-1).addr) : int'(exp_of(i0).addr);
            chk("idle_addr_hold", int'(addr), hold_addr);
            chk("idle_flags", int'({addr_valid, tap_first, tap_last, pixel_last}), 0);
            $display("idle en=%0b addr=%0d done=%0b", en, addr, done);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, idx=%0d", idx);
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int v0;
        reset  = 1'b0;
        enable = 1'b1;

        // Reset held with enable high
        repeat (2) @(negedge clk);
        chk("reset_addr",       int'(addr),       0);
        chk("reset_channel",    int'(channel),    0);
        chk("reset_done",       int'(done),       0);
        chk("reset_tap_first",  int'(tap_first),  1);
        chk("reset_addr_valid", int'(addr_valid), 1);
        chk("reset_tap_last",   int'(tap_last),   0);
        chk("reset_pixel_last", int'(pixel_last), 0);
        enable = 1'b0;
        #2 reset = 1'b1;

        // Run up to addr 14, stall 3 cycles, then continue randomly
        for (int i = 0; i < STALL_IDX; i++) step(1'b1);
        repeat (3) step(1'b0);
        g = 0;
        while (idx < RST_IDX && g < 20000) begin
            step($urandom_range(0, 9) < 8);
            g++;
        end
        chk("reach_reset_point", idx, RST_IDX);

        // Mid-run asynchronous reset at channel 1, pixel 20, tap 7
        @(posedge clk);
        #1;
        chk("pre_reset_addr",    int'(addr),    int'(exp_of(RST_IDX).addr));
        chk("pre_reset_channel", int'(channel), 1);
        reset  = 1'b0;
        enable = 1'b1;
        #1;
        chk("midreset_addr",    int'(addr),    0);
        chk("midreset_channel", int'(channel), 0);
        chk("midreset_done",    int'(done),    0);
        chk("queue_drained_at_reset", q.size(), 0);
        q.delete();
        idx = 0;
        @(negedge clk);
        enable = 1'b0;
        #2 reset = 1'b1;

        // Full run from the start
        v0 = n_valid;
        g  = 0;
        while (idx < TOTAL && g < 30000) begin
            step($urandom_range(0, 9) < 8);
            g++;
        end
        chk("run_complete", idx, TOTAL);

        // done holds and addr_valid stays low under continued enable
        repeat (5) step(1'b1);
        chk("valid_count", n_valid - v0, TOTAL);
        chk("queue_empty_end", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/conv2_fmap_mem_read.md
# conv2_fmap_mem_read

Address generator for the Convolution 2 layer input feature-map memory, which holds the pooled Convolution 1 output. Runs in lockstep with the Convolution 2 weight-memory addresser, one address per cycle. For every 8x8 output pixel of every input channel, it walks the matching 5x5 window of the 12x12 input map. The tap order is row-major, taps 0..24, identical to the weight tap order, so the MAC stage pairs feature-map word N with weight word N each cycle.

## Interface
Parameters:
- IN_W, 12, width/height of each square input map
- K, 5, kernel width/height
- OUT_W, 8, output map width/height (IN_W-K+1)
- CH, 3, number of input channels stored back to back
- ADDR_W, 9, address width; must satisfy CH*IN_W*IN_W <= 2^ADDR_W

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- enable  in  1  advance one tap per cycle while high and done low
- addr  out  ADDR_W  feature-map read address for the current tap
- addr_valid  out  1  enable && !done; addr is a live tap this cycle
- tap_first  out  1  addr_valid && tap index == 0 (start of window accumulation)
- tap_last  out  1  addr_valid && tap index == K*K-1 (end of window)
- pixel_last  out  1  tap_last && output pixel == OUT_W*OUT_W-1 (end of channel)
- channel  out  2  current input channel index, 0..CH-1
- done  out  1  registered; high once all CH*OUT_W*OUT_W*K*K taps issued; held until reset

## Operation
- State registers: kc, kr (0..K-1), oc, orow (0..OUT_W-1), ch (0..CH-1), and done.
- Registered bases: tap_off = kr*IN_W+kc, pix_base = orow*IN_W+oc, ch_base = ch*IN_W*IN_W.
- Bases are updated incrementally by adds only. No multipliers.
- addr = ch_base + pix_base + tap_off, combinational from registers, truncated to ADDR_W.
- Advance rule, on each rising edge with enable=1 and done=0:
  - Normally kc+1, tap_off+1.
  - If kc==K-1: kc=0, kr+1, tap_off += IN_W-(K-1).
  - If kc==K-1 and kr==K-1 (tap 24): kr=0, tap_off=0, and the output pixel advances.
    - Pixel advance: oc+1, pix_base+1.
    - If oc==OUT_W-1: oc=0, orow+1, pix_base += IN_W-(OUT_W-1).
  - If the last tap of pixel 63 is issued: orow=oc=0, pix_base=0, and the channel advances.
    - If ch<CH-1: ch+1, ch_base += IN_W*IN_W.
    - If ch==CH-1: done<=1, and all counters hold their final values.
- enable=0: all state holds; addr keeps its value; addr_valid and the flags are low.
- done=1: enable is ignored; addr_valid stays 0 until reset asserts.
- Reset asserted at any time, including mid-window: all counters, bases and done go to 0 asynchronously. After release, the sequence restarts at channel 0, pixel 0, tap 0.

## Timing
- Reset values:
  - addr=0, channel=0, done=0.
  - addr_valid, tap_first, tap_last, pixel_last follow enable: tap_first=enable, others 0.
- Throughput: one tap per enabled cycle. No bubbles between windows, pixels or channels.
- Window length is exactly 25 enabled cycles. This matches the weight addresser, which wraps every 25 taps and advances its offset after 64 pixels.
- Latency: addr is valid in the same cycle addr_valid is high. The memory read data appears one cycle later; the consumer aligns it.
- Full run: CH*64*25 = 4800 enabled cycles. done rises on the edge that consumes the final tap and is visible the next cycle.
- Simultaneous tap, pixel and channel wrap on one edge is legal and must update all three bases together.

## Test plan
- Reset:
  - reset low with enable=1 -> addr=0, channel=0, done=0, tap_first=1, addr_valid=1.
  - Release reset -> first addresses are 0,1,2,3,4,12,13,...,52 (25 taps), with tap_last on addr 52.
- Pixel steps:
  - Pixel 1 window starts at addr 1.
  - Pixel 8 (row 1, col 0) starts at 12.
  - Pixel 63 window spans 91..143.
  - pixel_last is high only on addr 143.
- Channel wrap: the tap after addr 143 is 144 with channel=1. Channel 2 first addr is 288. The final address is 431.
- Completion:
  - Count addr_valid cycles = 4800.
  - done=1 the cycle after addr 431 and stays high under continued enable.
  - addr_valid=0 while done is high.
- Stall: drop enable for 3 cycles mid-window at addr 14 -> addr holds 14, flags low. Resume yields 15, 16 with no skipped or repeated tap.
- Mid-run reset: assert reset at channel 1, pixel 20, tap 7 -> immediate addr=0, channel=0, done=0. The full 4800-tap sequence then repeats correctly.
